// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state type, operand width and two's-complement helpers.
package mips_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mdu_state_t;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: 32 shift-add or restoring
// shift-subtract steps on operand magnitudes, sign fix-up on the final cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mips_pkg::*;

  mdu_state_t  state_r;
  logic [5:0]  count_r;
  logic [1:0]  op_r;
  logic [31:0] a_r;
  logic [63:0] p_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        dz_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic        in_signed_s;
  logic        is_div_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_shift_s;
  logic [32:0] div_diff_s;
  logic        div_ok_s;
  logic [63:0] p_next_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;

  assign in_signed_s = (op == OP_MULT) || (op == OP_DIV);
  assign is_div_s    = (op_r == OP_DIV) || (op_r == OP_DIVU);

  // One iteration step and the sign-corrected result.
  // p_r holds {partial, multiplier} when multiplying and {remainder, quotient} when dividing.
  always_comb begin
    mul_sum_s   = {1'b0, p_r[63:32]} + (p_r[0] ? {1'b0, a_r} : 33'd0);
    div_shift_s = {p_r[63:32], p_r[31]};
    div_diff_s  = div_shift_s - {1'b0, a_r};
    // A set shifted-out bit means the partial remainder already exceeds any 32-bit divisor
    div_ok_s    = div_shift_s[32] | ~div_diff_s[32];
    if (is_div_s) begin
      if (div_ok_s) begin
        p_next_s = {div_diff_s[31:0], p_r[30:0], 1'b1};
      end else begin
        p_next_s = {div_shift_s[31:0], p_r[30:0], 1'b0};
      end
      res_lo_s = dz_r ? 32'hFFFF_FFFF : (neg_q_r ? neg32(p_r[31:0]) : p_r[31:0]);
      res_hi_s = neg_r_r ? neg32(p_r[63:32]) : p_r[63:32];
    end else begin
      p_next_s = {mul_sum_s, p_r[31:1]};
      {res_hi_s, res_lo_s} = neg_q_r ? neg64(p_r) : p_r;
    end
  end

  // Sequencing FSM and iterative datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      count_r <= 6'd0;
      op_r    <= 2'b00;
      a_r     <= 32'd0;
      p_r     <= 64'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RUN;
            count_r <= 6'd32;
            op_r    <= op;
            a_r     <= in_signed_s ? abs32(rt_data) : rt_data;
            p_r     <= {32'd0, (in_signed_s ? abs32(rs_data) : rs_data)};
            neg_q_r <= in_signed_s & (rs_data[31] ^ rt_data[31]);
            neg_r_r <= in_signed_s & rs_data[31];
            dz_r    <= (rt_data == 32'd0);
          end
        end
        RUN: begin
          p_r     <= p_next_s;
          count_r <= count_r - 6'd1;
          if (count_r == 6'd1) begin
            state_r <= FINISH;
          end
        end
        FINISH: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Architectural HI/LO and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= 32'd0;
      lo_r   <= 32'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            busy_r <= 1'b1;
          end else begin
            if (mthi) hi_r <= rs_data;
            if (mtlo) lo_r <= rs_data;
          end
        end
        RUN: begin
          busy_r <= 1'b1;
        end
        FINISH: begin
          hi_r   <= res_hi_s;
          lo_r   <= res_lo_s;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a cycle-level reference model built
// from plain arithmetic, compared against the DUT every falling edge.
module tb_mult_div_unit;

  localparam logic [1:0] T_MULT  = 2'b00;
  localparam logic [1:0] T_MULTU = 2'b01;
  localparam logic [1:0] T_DIV   = 2'b10;
  localparam logic [1:0] T_DIVU  = 2'b11;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  int          m_left = 0;
  logic [31:0] m_res_hi = 32'd0;
  logic [31:0] m_res_lo = 32'd0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of an operation, straight from integer arithmetic.
  task automatic model_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] rh, output logic [31:0] rl);
    longint      sa;
    longint      sb;
    longint      sq;
    longint      sr;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    rh = 32'd0;
    rl = 32'd0;
    case (o)
      T_MULT: begin
        p = sa * sb;
        rh = p[63:32];
        rl = p[31:0];
      end
      T_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        rh = p[63:32];
        rl = p[31:0];
      end
      T_DIV: begin
        if (b == 32'd0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          rh = sr[31:0];
          rl = sq[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else begin
          rh = a % b;
          rl = a / b;
        end
      end
    endcase
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    m_left = 0;
  endtask

  // Model one rising edge: a result lands 33 edges after the accepting edge.
  task automatic model_edge();
    m_done = 1'b0;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_hi   = m_res_hi;
        m_lo   = m_res_lo;
        m_done = 1'b1;
        m_busy = 1'b0;
      end
    end else if (start) begin
      model_calc(op, rs_data, rt_data, m_res_hi, m_res_lo);
      m_busy = 1'b1;
      m_left = 33;
    end else begin
      if (mthi) m_hi = rs_data;
      if (mtlo) m_lo = rs_data;
    end
  endtask

  task automatic step(input logic s, input logic [1:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic mh, input logic ml);
    start   = s;
    op      = o;
    rs_data = a;
    rt_data = b;
    mthi    = mh;
    mtlo    = ml;
    @(posedge clock);
    #1;
    if (!reset_n) model_reset();
    else model_edge();
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input string name);
    int lat;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check(name, 32'(lat), 32'd33);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Every cycle: DUT outputs against the reference model.
  always @(negedge clock) begin
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0; op = 2'b00; rs_data = 32'd0; rt_data = 32'd0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_hi", hi, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    // start accepted on the first edge after reset release
    step(1'b1, T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_busy", {31'd0, busy}, 32'd1);
    wait_done("multu_latency");
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    check("model_multu_hi", m_hi, 32'hFFFF_FFFE);

    step(1'b1, T_MULT, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0);
    wait_done("mult_latency");
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    check("model_mult_lo", m_lo, 32'hFFFF_FFEB);

    step(1'b1, T_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    wait_done("div_latency");
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("model_div_hi", m_hi, 32'hFFFF_FFFF);

    step(1'b1, T_DIVU, 32'd100, 32'd0, 1'b0, 1'b0);
    wait_done("divz_latency");
    check("divz_hi", hi, 32'd100);
    check("divz_lo", lo, 32'hFFFF_FFFF);

    step(1'b1, T_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
    wait_done("sdivz_latency");
    check("sdivz_hi", hi, 32'hFFFF_FFF9);
    check("sdivz_lo", lo, 32'hFFFF_FFFF);

    step(1'b1, T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    wait_done("divovf_latency");
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // moves in IDLE, then ignored moves and start while busy
    step(1'b0, 2'b00, 32'h1234, 32'd0, 1'b1, 1'b0);
    check("mthi_idle", hi, 32'h1234);
    step(1'b1, T_MULTU, 32'd5, 32'd6, 1'b0, 1'b0);
    step(1'b0, 2'b00, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1);
    check("mtlo_busy", lo, 32'h8000_0000);
    for (int i = 0; i < 7; i++) idle();
    step(1'b1, T_MULTU, 32'd7, 32'd7, 1'b0, 1'b0);
    for (int i = 0; i < 40 && done !== 1'b1; i++) idle();
    check("restart_ignored_hi", hi, 32'd0);
    check("restart_ignored_lo", lo, 32'd30);

    // reset in the middle of an operation
    step(1'b1, T_MULTU, 32'd3, 32'd3, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) idle();
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    model_reset();
    idle();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 25; i++) idle();

    // start wins over a simultaneous move
    step(1'b1, T_DIVU, 32'd9, 32'd4, 1'b0, 1'b1);
    check("start_beats_mtlo", lo, 32'd0);
    wait_done("divu_latency");
    check("divu_hi", hi, 32'd1);
    check("divu_lo", lo, 32'd2);

    // start on the FINISH edge is dropped; the next edge accepts
    step(1'b1, T_MULTU, 32'd2, 32'd3, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) idle();
    step(1'b1, T_MULTU, 32'd4, 32'd4, 1'b0, 1'b0);
    check("finish_done", {31'd0, done}, 32'd1);
    check("finish_lo", lo, 32'd6);
    step(1'b1, T_MULTU, 32'd4, 32'd4, 1'b0, 1'b0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    wait_done("restart_latency");
    check("restart_lo", lo, 32'd16);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), pick(), pick(),
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 40; i++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand width; only 32 is supported.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clock  input  1  rising-edge clock shared with registerfile.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle request to begin an operation.
REQ-006 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 rs_data  input  32  multiplicand or dividend, from registerfile Data1.
REQ-008 rt_data  input  32  multiplier or divisor, from registerfile Data2.
REQ-009 mthi  input  1  write rs_data into HI.
REQ-010 mtlo  input  1  write rs_data into LO.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when HI and LO update with a result.
REQ-013 hi  output  32  HI register; product[63:32] or remainder.
REQ-014 lo  output  32  LO register; product[31:0] or quotient.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-016 In IDLE, start SHALL capture op, rs_data and rt_data, load the count with 32, set busy and enter RUN on the same edge.
REQ-017 While busy, start, mthi and mtlo SHALL be ignored; no queuing.
REQ-018 RUN SHALL perform one iteration per cycle, either shift-add for multiply or restoring shift-subtract for divide; it SHALL last exactly 32 cycles and then enter FINISH.
REQ-019 FINISH SHALL apply sign correction, write hi/lo, pulse done for one cycle, clear busy and return to IDLE.
REQ-020 Latency: if start is sampled at edge N, hi, lo and done SHALL be valid after edge N+33, and busy SHALL be high after edges N through N+32.
REQ-021 Signed ops (MULT, DIV) SHALL iterate on operand magnitudes.
REQ-022 MULT: the 64-bit product SHALL be negated if the operand signs differ.
REQ-023 DIV: the quotient SHALL be negated if the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero SHALL give hi=rs_data and lo=32'hFFFFFFFF, with the normal 33-cycle latency and no error flag.
REQ-025 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-026 hi and lo SHALL hold their previous values throughout RUN and change only in FINISH or on mthi/mtlo.
REQ-027 In IDLE, mthi/mtlo SHALL load rs_data into hi/lo on the next edge.
REQ-028 mthi and mtlo asserted together SHALL load both hi and lo.
REQ-029 start asserted together with mthi/mtlo in IDLE: start SHALL win and the move SHALL be dropped.
REQ-030 start in FINISH SHALL be ignored; a new operation SHALL be accepted only from IDLE, so the earliest restart is edge N+34.

Reset
REQ-031 reset_n low SHALL immediately force: state=IDLE, busy=0, done=0, hi=0, lo=0, count=0, internal accumulators=0.
REQ-032 Reset during RUN or FINISH SHALL abort the operation with no partial hi/lo update.
REQ-033 After reset_n deasserts, start SHALL be accepted on the first rising edge.

Structure
REQ-034 Shared package mips_pkg SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the mdu_state_t enum and the WIDTH constant.
REQ-035 There SHALL be a single module with no sub-modules; the 33-bit subtractor and 64-bit accumulator are inline.
REQ-036 No multiplier or divider primitives SHALL be inferred; the datapath is iterative only.

Verification
REQ-037 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001, done exactly 33 cycles after start.
REQ-038 MULT -7 x 3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-039 DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 100 / 0 -> hi=100, lo=32'hFFFFFFFF.
REQ-040 mthi with rs=32'h1234 in IDLE -> hi=32'h1234 next edge; mtlo during busy -> lo unchanged.
REQ-041 Second start at cycle 10 of a MULTU 5x6 -> ignored, result hi=0, lo=30; reset_n low at cycle 15 of a new op -> hi=lo=0, busy=0 at once, no done pulse.
REQ-042 start with mtlo in IDLE, op DIVU 9/4 -> mtlo dropped, final hi=1, lo=2.
